// File: rtl/mul_unit.sv
// mul_unit: four-stage pipelined RV32M integer multiplier (MUL/MULH/MULHSU/MULHU).
//
// Build option:
//   MUL_UNIT_MULH_EN  defined   -> full 33x33 signed datapath, upper-half ops honoured
//                     undefined -> low-half datapath only, every funct3 yields MUL
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   iss_mul_oper        launch a multiply this cycle
//   iss_ex_rega/regb    operands rs1 / rs2
//   iss_ex_funct3       000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, others MUL
//   iss_ex_regdest      destination register
//   iss_ex_writereg     result writes the register file
//   wb_mul_ready        writeback accepts the tail result this cycle
//   mul_wb_valid/data/addr/writereg  tail (S4) result
//   mul_sb_release      scoreboard entry for mul_wb_addr clears this cycle (comb)
//   mul_iss_busy        launch cannot be accepted this cycle (comb)
//   mul_inflight        number of valid slots, 0..4 (comb from slot valids)
//   mul_err_overrun     sticky: a launch arrived while busy and was dropped
module mul_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        iss_mul_oper,
   input  logic [31:0] iss_ex_rega,
   input  logic [31:0] iss_ex_regb,
   input  logic [2:0]  iss_ex_funct3,
   input  logic [4:0]  iss_ex_regdest,
   input  logic        iss_ex_writereg,
   input  logic        wb_mul_ready,
   output logic        mul_wb_valid,
   output logic [31:0] mul_wb_data,
   output logic [4:0]  mul_wb_addr,
   output logic        mul_wb_writereg,
   output logic        mul_sb_release,
   output logic        mul_iss_busy,
   output logic [2:0]  mul_inflight,
   output logic        mul_err_overrun
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned HALF  = XLEN / 2;
   localparam int unsigned REG_W = 5;
   localparam int unsigned F3_W  = 3;
   localparam int unsigned NSLOT = 4;
   localparam int unsigned CNT_W = 3;

   // ------------------------------------------------------------------
   // Slot control: valid / funct3 / regdest / writereg, index 0 = S1
   // ------------------------------------------------------------------
   logic                        advance;
   logic                        accept;
   logic [NSLOT-1:0]            slot_valid;
   logic [NSLOT-1:0][F3_W-1:0]  slot_funct3;
   logic [NSLOT-1:0][REG_W-1:0] slot_dest;
   logic [NSLOT-1:0]            slot_wr;
   logic [F3_W-1:0]             s4_funct3_unused;

   // Whole pipe moves together; only a tail result refused by writeback stalls it
   assign advance = !(slot_valid[NSLOT-1] && !wb_mul_ready);
   assign accept  = slot_valid[NSLOT-1] && wb_mul_ready;

   // Shift register of per-slot control fields
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_valid  <= '0;
         slot_funct3 <= '0;
         slot_dest   <= '0;
         slot_wr     <= '0;
      end else if (advance) begin
         slot_valid  <= {slot_valid[NSLOT-2:0], iss_mul_oper};
         slot_funct3 <= {slot_funct3[NSLOT-2:0], iss_ex_funct3};
         slot_dest   <= {slot_dest[NSLOT-2:0], iss_ex_regdest};
         slot_wr     <= {slot_wr[NSLOT-2:0], iss_ex_writereg};
      end
   end

   // Result selection happens on the S3->S4 move, so the S4 copy is informational
   assign s4_funct3_unused = slot_funct3[NSLOT-1];

   // Sticky overrun: a launch offered while stalled is dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_err_overrun <= 1'b0;
      end else if (iss_mul_oper && !advance) begin
         mul_err_overrun <= 1'b1;
      end
   end

`ifdef MUL_UNIT_MULH_EN
   // ------------------------------------------------------------------
   // Full datapath: 33x33 signed product built from 17x17 partials
   // ------------------------------------------------------------------
   localparam int unsigned OP_W  = XLEN + 1;
   localparam int unsigned PP_W  = 2 * (HALF + 1);
   localparam int unsigned SUM_W = 2 * XLEN;

   localparam logic [F3_W-1:0] F3_MULH   = 3'b001;
   localparam logic [F3_W-1:0] F3_MULHSU = 3'b010;
   localparam logic [F3_W-1:0] F3_MULHU  = 3'b011;

   logic                   a_sx;
   logic                   b_sx;
   logic [OP_W-1:0]        a_ext;
   logic [OP_W-1:0]        b_ext;
   logic [OP_W-1:0]        s1_a;
   logic [OP_W-1:0]        s1_b;
   logic signed [HALF:0]   a_lo;
   logic signed [HALF:0]   a_hi;
   logic signed [HALF:0]   b_lo;
   logic signed [HALF:0]   b_hi;
   logic signed [PP_W-1:0] pp_ll;
   logic signed [PP_W-1:0] pp_lh;
   logic signed [PP_W-1:0] pp_hl;
   logic signed [PP_W-1:0] pp_hh;
   logic signed [PP_W-1:0] s2_p_ll;
   logic signed [PP_W-1:0] s2_p_lh;
   logic signed [PP_W-1:0] s2_p_hl;
   logic signed [PP_W-1:0] s2_p_hh;
   logic [SUM_W-1:0]       sum;
   logic [SUM_W-1:0]       s3_sum;
   logic [XLEN-1:0]        res;
   logic [XLEN-1:0]        s4_data;

   // S1 operand extension: the 33rd bit is the sign only for signed operands
   always_comb begin
      a_sx = 1'b0;
      b_sx = 1'b0;
      case (iss_ex_funct3)
         F3_MULH: begin
            a_sx = 1'b1;
            b_sx = 1'b1;
         end
         F3_MULHSU: a_sx = 1'b1;
         default:   ;
      endcase
      a_ext = {a_sx & iss_ex_rega[XLEN-1], iss_ex_rega};
      b_ext = {b_sx & iss_ex_regb[XLEN-1], iss_ex_regb};
   end

   // S2 partials: low halves are non-negative, high halves carry the sign
   always_comb begin
      a_lo  = $signed({1'b0, s1_a[HALF-1:0]});
      a_hi  = $signed(s1_a[OP_W-1:HALF]);
      b_lo  = $signed({1'b0, s1_b[HALF-1:0]});
      b_hi  = $signed(s1_b[OP_W-1:HALF]);
      pp_ll = PP_W'(a_lo) * PP_W'(b_lo);
      pp_lh = PP_W'(a_lo) * PP_W'(b_hi);
      pp_hl = PP_W'(a_hi) * PP_W'(b_lo);
      pp_hh = PP_W'(a_hi) * PP_W'(b_hi);
   end

   // S3 sum; 64 bits is enough since only product[63:0] is ever selected
   assign sum = SUM_W'(s2_p_ll)
              + (SUM_W'(s2_p_lh) << HALF)
              + (SUM_W'(s2_p_hl) << HALF)
              + (SUM_W'(s2_p_hh) << XLEN);

   // S4 half select from the funct3 travelling alongside S3
   always_comb begin
      case (slot_funct3[NSLOT-2])
         F3_MULH, F3_MULHSU, F3_MULHU: res = s3_sum[SUM_W-1:XLEN];
         default:                      res = s3_sum[XLEN-1:0];
      endcase
   end

   // Datapath registers hold whenever the pipe stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_a    <= '0;
         s1_b    <= '0;
         s2_p_ll <= '0;
         s2_p_lh <= '0;
         s2_p_hl <= '0;
         s2_p_hh <= '0;
         s3_sum  <= '0;
         s4_data <= '0;
      end else if (advance) begin
         s1_a    <= a_ext;
         s1_b    <= b_ext;
         s2_p_ll <= pp_ll;
         s2_p_lh <= pp_lh;
         s2_p_hl <= pp_hl;
         s2_p_hh <= pp_hh;
         s3_sum  <= sum;
         s4_data <= res;
      end
   end
`else
   // ------------------------------------------------------------------
   // Low-half datapath: only product[31:0]; sign handling is irrelevant
   // ------------------------------------------------------------------
   logic [XLEN-1:0] s1_a;
   logic [XLEN-1:0] s1_b;
   logic [XLEN-1:0] pp_ll;
   logic [HALF-1:0] pp_lh;
   logic [HALF-1:0] pp_hl;
   logic [XLEN-1:0] s2_p_ll;
   logic [HALF-1:0] s2_p_lh;
   logic [HALF-1:0] s2_p_hl;
   logic [XLEN-1:0] sum;
   logic [XLEN-1:0] s3_sum;
   logic [XLEN-1:0] s4_data;

   // S2 partials; cross terms only contribute their low 16 bits to the result
   always_comb begin
      pp_ll = XLEN'(s1_a[HALF-1:0]) * XLEN'(s1_b[HALF-1:0]);
      pp_lh = s1_a[HALF-1:0] * s1_b[XLEN-1:HALF];
      pp_hl = s1_a[XLEN-1:HALF] * s1_b[HALF-1:0];
   end

   assign sum = s2_p_ll + {s2_p_lh, {HALF{1'b0}}} + {s2_p_hl, {HALF{1'b0}}};

   // Datapath registers hold whenever the pipe stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_a    <= '0;
         s1_b    <= '0;
         s2_p_ll <= '0;
         s2_p_lh <= '0;
         s2_p_hl <= '0;
         s3_sum  <= '0;
         s4_data <= '0;
      end else if (advance) begin
         s1_a    <= iss_ex_rega;
         s1_b    <= iss_ex_regb;
         s2_p_ll <= pp_ll;
         s2_p_lh <= pp_lh;
         s2_p_hl <= pp_hl;
         s3_sum  <= sum;
         s4_data <= s3_sum;
      end
   end
`endif

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign mul_wb_valid    = slot_valid[NSLOT-1];
   assign mul_wb_data     = s4_data;
   assign mul_wb_addr     = slot_dest[NSLOT-1];
   assign mul_wb_writereg = slot_wr[NSLOT-1];

   // x0 is never tracked by the scoreboard, so no release for it
   assign mul_sb_release  = accept && slot_wr[NSLOT-1] && (slot_dest[NSLOT-1] != '0);
   assign mul_iss_busy    = !advance;
   assign mul_inflight    = CNT_W'($countones(slot_valid));

endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: directed + randomized bench for mul_unit with a queue-based reference model.
module tb_mul_unit;

`ifdef MUL_UNIT_MULH_EN
   localparam bit          MULH_EN  = 1'b1;
   localparam logic [31:0] E_MULH   = 32'h0000_0000;
   localparam logic [31:0] E_MULHU  = 32'hFFFF_FFFE;
   localparam logic [31:0] E_MULHSU = 32'hFFFF_FFFF;
`else
   localparam bit          MULH_EN  = 1'b0;
   localparam logic [31:0] E_MULH   = 32'h0000_0001;
   localparam logic [31:0] E_MULHU  = 32'h0000_0001;
   localparam logic [31:0] E_MULHSU = 32'h0000_0001;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        iss_mul_oper;
   logic [31:0] iss_ex_rega;
   logic [31:0] iss_ex_regb;
   logic [2:0]  iss_ex_funct3;
   logic [4:0]  iss_ex_regdest;
   logic        iss_ex_writereg;
   logic        wb_mul_ready;
   logic        mul_wb_valid;
   logic [31:0] mul_wb_data;
   logic [4:0]  mul_wb_addr;
   logic        mul_wb_writereg;
   logic        mul_sb_release;
   logic        mul_iss_busy;
   logic [2:0]  mul_inflight;
   logic        mul_err_overrun;

   always #5 clk = ~clk;

   mul_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .iss_mul_oper    (iss_mul_oper),
      .iss_ex_rega     (iss_ex_rega),
      .iss_ex_regb     (iss_ex_regb),
      .iss_ex_funct3   (iss_ex_funct3),
      .iss_ex_regdest  (iss_ex_regdest),
      .iss_ex_writereg (iss_ex_writereg),
      .wb_mul_ready    (wb_mul_ready),
      .mul_wb_valid    (mul_wb_valid),
      .mul_wb_data     (mul_wb_data),
      .mul_wb_addr     (mul_wb_addr),
      .mul_wb_writereg (mul_wb_writereg),
      .mul_sb_release  (mul_sb_release),
      .mul_iss_busy    (mul_iss_busy),
      .mul_inflight    (mul_inflight),
      .mul_err_overrun (mul_err_overrun)
   );

   // Reference model: ops in flight, oldest first, with the number of stages reached
   typedef struct {
      logic [31:0] data;
      logic [4:0]  dest;
      logic        wr;
      int          age;
   } op_t;

   op_t  q[$];
   logic exp_err;
   int   tests;
   int   fails;

   function automatic logic [31:0] ref_mul(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [63:0] sa, sb, ua, ub;
      logic [63:0]        p;
      sa = 64'($signed(a));
      sb = 64'($signed(b));
      ua = 64'(a);
      ub = 64'(b);
      case (f)
         3'b001:  p = sa * sb;
         3'b010:  p = sa * ub;
         default: p = ua * ub;
      endcase
      if (!MULH_EN || f == 3'b000 || f > 3'b011) return a * b;
      return p[63:32];
   endfunction

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Compare every output against the model at the current (pre-edge) state
   task automatic check_outputs();
      logic ev;
      ev = (q.size() > 0) && (q[0].age == 4);
      chk("wb_valid", 32'(mul_wb_valid), 32'(ev));
      chk("iss_busy", 32'(mul_iss_busy), 32'(ev && !wb_mul_ready));
      chk("sb_release", 32'(mul_sb_release),
          32'(ev && wb_mul_ready && q[0].wr && (q[0].dest != 5'd0)));
      chk("inflight", 32'(mul_inflight), 32'(q.size()));
      chk("overrun", 32'(mul_err_overrun), 32'(exp_err));
      if (ev) begin
         chk("wb_data", mul_wb_data, q[0].data);
         chk("wb_addr", 32'(mul_wb_addr), 32'(q[0].dest));
         chk("wb_writereg", 32'(mul_wb_writereg), 32'(q[0].wr));
      end
   endtask

   task automatic drive(input logic l, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d, input logic w,
                        input logic r);
      iss_mul_oper    = l;
      iss_ex_funct3   = f;
      iss_ex_rega     = a;
      iss_ex_regb     = b;
      iss_ex_regdest  = d;
      iss_ex_writereg = w;
      wb_mul_ready    = r;
      @(negedge clk);
      check_outputs();
   endtask

   // Clock edge: advance the model exactly as the inputs dictate
   task automatic tick();
      logic ev;
      op_t  op;
      @(posedge clk);
      ev = (q.size() > 0) && (q[0].age == 4);
      if (ev && !wb_mul_ready) begin
         if (iss_mul_oper) exp_err = 1'b1;
      end else begin
         if (ev) void'(q.pop_front());
         foreach (q[i]) q[i].age++;
         if (iss_mul_oper) begin
            op.data = ref_mul(iss_ex_funct3, iss_ex_rega, iss_ex_regb);
            op.dest = iss_ex_regdest;
            op.wr   = iss_ex_writereg;
            op.age  = 1;
            q.push_back(op);
         end
      end
      #1;
   endtask

   task automatic cyc(input logic l, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] d, input logic w,
                      input logic r);
      drive(l, f, a, b, d, w, r);
      tick();
   endtask

   task automatic idle(input int n, input logic r);
      repeat (n) cyc(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, r);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tests           = 0;
      fails           = 0;
      exp_err         = 1'b0;
      rst_n           = 1'b0;
      iss_mul_oper    = 1'b0;
      iss_ex_funct3   = 3'd0;
      iss_ex_rega     = 32'd0;
      iss_ex_regb     = 32'd0;
      iss_ex_regdest  = 5'd0;
      iss_ex_writereg = 1'b0;
      wb_mul_ready    = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(mul_wb_valid), 32'd0);
      chk("rst_release", 32'(mul_sb_release), 32'd0);
      chk("rst_inflight", 32'(mul_inflight), 32'd0);
      chk("rst_overrun", 32'(mul_err_overrun), 32'd0);
      chk("rst_busy", 32'(mul_iss_busy), 32'd0);
      chk("rst_data", mul_wb_data, 32'd0);
      chk("rst_addr", 32'(mul_wb_addr), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // MUL 7 x -3: result after the 4th edge
      cyc(1'b1, 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1, 1'b1);
      idle(3, 1'b1);
      drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
      chk("mul7x-3_valid", 32'(mul_wb_valid), 32'd1);
      chk("mul7x-3_data", mul_wb_data, 32'hFFFF_FFEB);
      chk("mul7x-3_addr", 32'(mul_wb_addr), 32'd5);
      chk("mul7x-3_release", 32'(mul_sb_release), 32'd1);
      tick();

      // -1 x -1 through the three upper-half encodings, back to back
      cyc(1'b1, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b1, 1'b1);
      cyc(1'b1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1, 1'b1);
      cyc(1'b1, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1, 1'b1);
      idle(1, 1'b1);
      drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
      chk("mulh_m1", mul_wb_data, E_MULH);
      tick();
      drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
      chk("mulhu_m1", mul_wb_data, E_MULHU);
      tick();
      drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
      chk("mulhsu_m1", mul_wb_data, E_MULHSU);
      tick();
      idle(2, 1'b1);

      // Four back-to-back launches with writeback always ready
      for (int i = 0; i < 4; i++)
         cyc(1'b1, 3'($urandom_range(0, 3)), rnd_op(), rnd_op(), 5'(i + 8), 1'b1, 1'b1);
      drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
      chk("b2b_inflight_peak", 32'(mul_inflight), 32'd4);
      chk("b2b_busy", 32'(mul_iss_busy), 32'd0);
      tick();
      idle(4, 1'b1);

      // Full pipe, writeback stalled for three cycles, one dropped launch
      for (int i = 0; i < 4; i++)
         cyc(1'b1, 3'($urandom_range(0, 7)), rnd_op(), rnd_op(), 5'(i + 16), 1'b1, 1'b0);
      drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
      chk("stall_busy", 32'(mul_iss_busy), 32'd1);
      chk("stall_inflight", 32'(mul_inflight), 32'd4);
      tick();
      idle(1, 1'b0);
      drive(1'b1, 3'b000, 32'd3, 32'd3, 5'd30, 1'b1, 1'b0);
      chk("stall_launch_busy", 32'(mul_iss_busy), 32'd1);
      tick();
      drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
      chk("overrun_set", 32'(mul_err_overrun), 32'd1);
      tick();
      idle(5, 1'b1);
      drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
      chk("drained_inflight", 32'(mul_inflight), 32'd0);
      tick();

      // Write to x0: valid but no release
      cyc(1'b1, 3'b000, 32'd9, 32'd9, 5'd0, 1'b1, 1'b1);
      idle(3, 1'b1);
      drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
      chk("x0_valid", 32'(mul_wb_valid), 32'd1);
      chk("x0_release", 32'(mul_sb_release), 32'd0);
      tick();

      // Reset with two ops in flight
      cyc(1'b1, 3'b000, 32'd11, 32'd13, 5'd7, 1'b1, 1'b1);
      cyc(1'b1, 3'b011, 32'd17, 32'd19, 5'd9, 1'b1, 1'b1);
      iss_mul_oper = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_inflight", 32'(mul_inflight), 32'd0);
      chk("midrst_valid", 32'(mul_wb_valid), 32'd0);
      chk("midrst_release", 32'(mul_sb_release), 32'd0);
      chk("midrst_overrun", 32'(mul_err_overrun), 32'd0);
      q.delete();
      exp_err = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle(6, 1'b1);

      // Randomized traffic with random writeback backpressure
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), rnd_op(), rnd_op(),
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 9) < 7);
      idle(8, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
